// File: rtl/i2s_sample_scheduler.sv
// Feeds the I2S transmitter one word per tx_ready rising edge, sourced from ROM
// playback or a valid/ready stream, through a single-word prefetch buffer.
module i2s_sample_scheduler #(
   parameter int WIDTH  = 4,
   parameter int ADDR_W = 7,
   parameter int CNT_W  = 8
) (
   input  logic                 clock_i,
   input  logic                 nreset_i,
   input  logic                 enable_i,
   input  logic                 mode_i,
   input  logic                 loop_i,
   input  logic [ADDR_W-1:0]    start_addr_i,
   input  logic [ADDR_W-1:0]    end_addr_i,
   output logic [ADDR_W-1:0]    rom_addr_o,
   input  logic [2*WIDTH-1:0]   rom_data_i,
   input  logic                 stream_valid_i,
   input  logic [2*WIDTH-1:0]   stream_data_i,
   output logic                 stream_ready_o,
   input  logic                 tx_ready_i,
   output logic [2*WIDTH-1:0]   tx_word_o,
   output logic [CNT_W-1:0]     underrun_cnt_o,
   output logic                 done_o
);

   localparam int DW = 2 * WIDTH;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_FULL, S_STREAM, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   start_q, start_d;
   logic [ADDR_W-1:0]   end_q, end_d;
   logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
   logic                loop_q, loop_d;
   logic [DW-1:0]       buf_q, buf_d;
   logic                buf_vld_q, buf_vld_d;
   logic [DW-1:0]       tx_word_q, tx_word_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          sync_q;
   logic                take;
   logic                stream_ready;
   logic                hs;

   // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the edge-detect history
   assign take         = sync_q[1] & ~sync_q[2];
   assign stream_ready = enable_i && (state_q == S_STREAM) && !buf_vld_q;
   assign hs           = stream_ready && stream_valid_i;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      start_d    = start_q;
      end_d      = end_q;
      loop_d     = loop_q;
      rom_addr_d = rom_addr_q;
      buf_d      = buf_q;
      buf_vld_d  = buf_vld_q;
      tx_word_d  = tx_word_q;
      cnt_d      = cnt_q;

      // A take coinciding with an abort is dropped so tx_word/count hold
      if (take && (enable_i || state_q == S_IDLE)) begin
         if (buf_vld_q) begin
            tx_word_d = buf_q;
            buf_vld_d = 1'b0;
         end else begin
            tx_word_d = '0;
            if (state_q != S_IDLE && state_q != S_DONE && cnt_q != '1)
               cnt_d = cnt_q + CNT_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (enable_i) begin
               loop_d  = loop_i;
               start_d = start_addr_i;
               end_d   = end_addr_i;
               addr_d  = start_addr_i;
               state_d = mode_i ? S_STREAM : S_FETCH;
            end
         end
         S_FETCH: begin
            if (enable_i)
               rom_addr_d = addr_q;
            state_d = S_WAIT;
         end
         S_WAIT:  state_d = S_LOAD;
         S_LOAD: begin
            buf_d     = rom_data_i;
            buf_vld_d = 1'b1;
            if (addr_q == end_q) begin
               if (loop_q) begin
                  addr_d  = start_q;
                  state_d = S_FULL;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = S_FULL;
            end
         end
         S_FULL: begin
            if (take && buf_vld_q)
               state_d = S_FETCH;
         end
         S_STREAM: begin
            if (hs) begin
               buf_d     = stream_data_i;
               buf_vld_d = 1'b1;
            end
         end
         S_DONE:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase

      if (!enable_i) begin
         state_d   = S_IDLE;
         buf_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clock_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         start_q    <= '0;
         end_q      <= '0;
         loop_q     <= 1'b0;
         rom_addr_q <= '0;
         buf_q      <= '0;
         buf_vld_q  <= 1'b0;
         tx_word_q  <= '0;
         cnt_q      <= '0;
         sync_q     <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         start_q    <= start_d;
         end_q      <= end_d;
         loop_q     <= loop_d;
         rom_addr_q <= rom_addr_d;
         buf_q      <= buf_d;
         buf_vld_q  <= buf_vld_d;
         tx_word_q  <= tx_word_d;
         cnt_q      <= cnt_d;
         sync_q     <= {sync_q[1:0], tx_ready_i};
      end
   end

   assign rom_addr_o     = rom_addr_q;
   assign stream_ready_o = stream_ready;
   assign tx_word_o      = tx_word_q;
   assign underrun_cnt_o = cnt_q;
   assign done_o         = (state_q == S_DONE);

endmodule

// File: tb/tb_i2s_sample_scheduler.sv
// Self-checking bench: event-level reference model of the scheduler compared every
// cycle against two instances (default and 2-bit underrun counter).
module tb_i2s_sample_scheduler;

   logic       clk = 1'b0;
   logic       nreset = 1'b1;
   logic       enable = 1'b0;
   logic       mode = 1'b0;
   logic       loop = 1'b0;
   logic [6:0] start_addr = '0;
   logic [6:0] end_addr = '0;
   logic [6:0] rom_addr, rom_addr2;
   logic [7:0] rom_data = '0, rom_data2 = '0;
   logic       stream_valid = 1'b0;
   logic [7:0] stream_data = '0;
   logic       stream_ready, stream_ready2;
   logic       tx_ready = 1'b0;
   logic [7:0] tx_word, tx_word2;
   logic [7:0] ucnt;
   logic [1:0] ucnt2;
   logic       done, done2;
   logic [7:0] rom [128];

   int n_checks = 0;
   int n_pass = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rom_data  <= rom[rom_addr];
      rom_data2 <= rom[rom_addr2];
   end

   i2s_sample_scheduler dut (
      .clock_i(clk), .nreset_i(nreset), .enable_i(enable), .mode_i(mode), .loop_i(loop),
      .start_addr_i(start_addr), .end_addr_i(end_addr), .rom_addr_o(rom_addr),
      .rom_data_i(rom_data), .stream_valid_i(stream_valid), .stream_data_i(stream_data),
      .stream_ready_o(stream_ready), .tx_ready_i(tx_ready), .tx_word_o(tx_word),
      .underrun_cnt_o(ucnt), .done_o(done)
   );

   i2s_sample_scheduler #(.CNT_W(2)) dut_sat (
      .clock_i(clk), .nreset_i(nreset), .enable_i(enable), .mode_i(mode), .loop_i(loop),
      .start_addr_i(start_addr), .end_addr_i(end_addr), .rom_addr_o(rom_addr2),
      .rom_data_i(rom_data2), .stream_valid_i(stream_valid), .stream_data_i(stream_data),
      .stream_ready_o(stream_ready2), .tx_ready_i(tx_ready), .tx_word_o(tx_word2),
      .underrun_cnt_o(ucnt2), .done_o(done2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Words are tracked as events: a fetch requested at one edge puts its address on
   // the ROM one edge later and lands in the buffer three edges later.
   bit         m_run, m_mode, m_loop, m_done, m_buf_vld;
   bit         h0, h1, h2;
   logic [7:0] m_buf, m_tx;
   logic [6:0] m_start, m_end, m_next, m_fetch, m_rom_addr;
   int         m_under, m_cd;

   task automatic m_reset();
      m_run = 0; m_mode = 0; m_loop = 0; m_done = 0; m_buf_vld = 0;
      h0 = 0; h1 = 0; h2 = 0;
      m_buf = '0; m_tx = '0; m_start = '0; m_end = '0; m_next = '0; m_fetch = '0;
      m_rom_addr = '0; m_under = 0; m_cd = 0;
   endtask

   task automatic log_take();
      $display("take t=%0t tx_word=%02h underruns=%0d", $time, m_tx, m_under);
   endtask

   task automatic m_step();
      bit take, req, hs, pre_vld;
      take = h1 && !h2;
      h2 = h1; h1 = h0; h0 = tx_ready;
      req = 0;
      pre_vld = m_buf_vld;
      if (!enable) begin
         if (take && !m_run) begin m_tx = '0; log_take(); end
         m_run = 0; m_buf_vld = 0; m_cd = 0; m_done = 0;
      end else if (!m_run) begin
         if (take) begin m_tx = '0; log_take(); end
         m_run = 1; m_mode = mode; m_loop = loop; m_start = start_addr; m_end = end_addr;
         m_done = 0;
         if (!mode) begin m_next = start_addr; req = 1; end
      end else begin
         hs = m_mode && !pre_vld && stream_valid;
         if (take) begin
            if (pre_vld) begin
               m_tx = m_buf; m_buf_vld = 0;
               if (!m_mode && !m_done) req = 1;
            end else begin
               m_tx = '0;
               if (!m_done) m_under++;
            end
            log_take();
         end
         if (hs) begin m_buf = stream_data; m_buf_vld = 1; end
         if (m_cd > 0) begin
            m_cd--;
            if (m_cd == 2) m_rom_addr = m_fetch;
            if (m_cd == 0) begin
               m_buf = rom[m_fetch]; m_buf_vld = 1;
               if (m_fetch == m_end) begin
                  if (m_loop) m_next = m_start;
                  else m_done = 1;
               end else m_next = m_fetch + 7'd1;
            end
         end
      end
      if (req) begin m_cd = 3; m_fetch = m_next; end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge nreset);
         if (!nreset) m_reset();
         else m_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            chk("rom_addr", rom_addr, m_rom_addr);
            chk("tx_word", tx_word, m_tx);
            chk("underrun_cnt", ucnt, (m_under > 255) ? 255 : m_under);
            chk("done", done, m_done);
            chk("stream_ready", stream_ready, m_run && m_mode && !m_buf_vld && enable);
            chk("sat_rom_addr", rom_addr2, m_rom_addr);
            chk("sat_tx_word", tx_word2, m_tx);
            chk("sat_underrun_cnt", ucnt2, (m_under > 3) ? 3 : m_under);
            chk("sat_done", done2, m_done);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse();
      tx_ready = 1'b1;
      ticks(16);
      tx_ready = 1'b0;
      ticks(16);
   endtask

   task automatic take_expect(input string nm, input logic [7:0] exp);
      pulse();
      chk(nm, tx_word, exp);
      chk({nm, "_model"}, m_tx, exp);
   endtask

   task automatic start_cfg(input bit md, input bit lp, input logic [6:0] s, input logic [6:0] e);
      enable = 1'b0;
      ticks(2);
      mode = md; loop = lp; start_addr = s; end_addr = e;
      enable = 1'b1;
      ticks(10);
   endtask

   initial begin
      int hcnt;
      for (int i = 0; i < 128; i++) rom[i] = 8'($urandom_range(0, 255));
      rom[0] = 8'h3C;
      rom[2] = 8'hA1; rom[3] = 8'hB2; rom[4] = 8'hC3;
      rom[5] = 8'h11; rom[6] = 8'h22;

      #2 nreset = 1'b0;
      ticks(2);
      cmp_en = 1'b1;
      chk("reset_rom_addr", rom_addr, 0);
      chk("reset_tx_word", tx_word, 0);
      chk("reset_underrun", ucnt, 0);
      chk("reset_done", done, 0);
      chk("reset_stream_ready", stream_ready, 0);
      nreset = 1'b1;
      ticks(2);

      // ROM non-loop playback
      start_cfg(0, 0, 7'd2, 7'd4);
      take_expect("rom_w0", 8'hA1);
      chk("rom_done_early", done, 0);
      take_expect("rom_w1", 8'hB2);
      chk("rom_done_set", done, 1);
      take_expect("rom_w2", 8'hC3);
      take_expect("rom_after_done", 8'h00);
      chk("rom_no_underrun", ucnt, 0);
      enable = 1'b0;
      tick();
      chk("done_clear_on_disable", done, 0);

      // ROM loop playback
      start_cfg(0, 1, 7'd5, 7'd6);
      for (int k = 0; k < 5; k++) begin
         take_expect($sformatf("loop_w%0d", k), (k % 2 == 0) ? 8'h11 : 8'h22);
         chk("loop_addr_range", (rom_addr >= 7'd5) && (rom_addr <= 7'd6), 1);
      end

      // Stream underruns, then a handshaken word
      stream_valid = 1'b0;
      start_cfg(1, 0, 7'd0, 7'd0);
      for (int k = 0; k < 3; k++) take_expect($sformatf("stream_under%0d", k), 8'h00);
      chk("stream_under_cnt", ucnt, 3);
      chk("stream_ready_empty", stream_ready, 1);
      stream_valid = 1'b1; stream_data = 8'h5A;
      tick();
      stream_valid = 1'b0;
      chk("stream_ready_drop", stream_ready, 0);
      take_expect("stream_5a", 8'h5A);
      chk("stream_cnt_hold", ucnt, 3);

      // Saturation of the 2-bit counter
      take_expect("sat_under3", 8'h00);
      take_expect("sat_under4", 8'h00);
      chk("sat_cnt_saturated", ucnt2, 3);
      chk("sat_main_cnt", ucnt, 5);

      // Handshake on the same edge as the take pulse
      tx_ready = 1'b1;
      ticks(2);
      stream_valid = 1'b1; stream_data = 8'h7E;
      tick();
      stream_valid = 1'b0;
      chk("collide_cnt", ucnt, 6);
      chk("collide_tx", tx_word, 0);
      chk("collide_buffer_full", stream_ready, 0);
      ticks(13);
      tx_ready = 1'b0;
      ticks(16);
      take_expect("collide_next", 8'h7E);
      chk("collide_sat_cnt", ucnt2, 3);

      // Abort during the ROM wait state, then restart at address 0
      enable = 1'b0;
      ticks(2);
      mode = 1'b0; loop = 1'b0; start_addr = 7'h40; end_addr = 7'h45;
      enable = 1'b1;
      ticks(2);
      enable = 1'b0;
      tick();
      chk("abort_done", done, 0);
      chk("abort_stream_ready", stream_ready, 0);
      chk("abort_model_buf_empty", m_buf_vld, 0);
      start_addr = 7'd0; end_addr = 7'd3;
      enable = 1'b1;
      ticks(10);
      take_expect("abort_restart", 8'h3C);

      // Randomized operation
      for (int seg = 0; seg < 25; seg++) begin
         logic [6:0] s;
         s = 7'($urandom_range(0, 127));
         start_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s,
                   s + 7'($urandom_range(0, 5)));
         hcnt = 0;
         for (int c = 0; c < 300; c++) begin
            if (hcnt == 0) begin
               tx_ready = !tx_ready;
               hcnt = $urandom_range(1, 20);
            end else hcnt--;
            stream_valid = ($urandom_range(0, 3) != 0);
            stream_data = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            if ($urandom_range(0, 49) == 0) begin
               mode = 1'($urandom_range(0, 1));
               loop = 1'($urandom_range(0, 1));
               start_addr = 7'($urandom_range(0, 127));
               end_addr = 7'($urandom_range(0, 127));
            end
            tick();
         end
         enable = 1'b0;
         ticks(3);
      end

      // Asynchronous reset in the middle of streaming
      tx_ready = 1'b0;
      ticks(4);
      stream_valid = 1'b1; stream_data = 8'h99;
      start_cfg(1, 0, 7'd0, 7'd0);
      take_expect("pre_reset_word", 8'h99);
      tx_ready = 1'b1;
      ticks(2);
      #2 nreset = 1'b0;
      #1;
      chk("async_rom_addr", rom_addr, 0);
      chk("async_tx_word", tx_word, 0);
      chk("async_underrun", ucnt, 0);
      chk("async_done", done, 0);
      chk("async_stream_ready", stream_ready, 0);
      chk("async_sat_underrun", ucnt2, 0);
      tx_ready = 1'b0;
      stream_valid = 1'b0;
      enable = 1'b0;
      ticks(2);
      nreset = 1'b1;
      ticks(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/i2s_sample_scheduler.md
Name: i2s_sample_scheduler

Overview:
- Sequences sample words into the I2S transmitter's Tx input.
- Selects between ROM playback (address generation with start/end/loop) and a valid/ready streaming source.
- Keeps a one-word prefetch buffer so a word is always staged when the transmitter signals ready. Counts underruns.
- Sits between the sample sources and the transmitter, in the master-clock domain.

Parameters:
- WIDTH, 4: half-frame width; sample word is 2*WIDTH bits (left/right concatenated).
- ADDR_W, 7: ROM address width.
- CNT_W, 8: underrun counter width.

Ports:
- clock  in  1  master clock, single clock domain.
- nreset  in  1  asynchronous active-low reset.
- enable  in  1  run request; low flushes and idles.
- mode  in  1  0 = ROM playback, 1 = stream; sampled only in IDLE.
- loop  in  1  ROM mode: wrap end_addr->start_addr; sampled only in IDLE.
- start_addr  in  ADDR_W  first ROM address; sampled only in IDLE.
- end_addr  in  ADDR_W  last ROM address (inclusive); sampled only in IDLE.
- rom_addr  out  ADDR_W  ROM address.
- rom_data  in  2*WIDTH  ROM word, valid 1 cycle after rom_addr.
- stream_valid  in  1  stream word offered.
- stream_data  in  2*WIDTH  stream word.
- stream_ready  out  1  scheduler accepts stream word.
- tx_ready  in  1  transmitter ready (slower divided-clock domain; level).
- tx_word  out  2*WIDTH  word presented to transmitter Tx.
- underrun_cnt  out  CNT_W  saturating underrun count.
- done  out  1  ROM non-loop playback finished.

Behaviour:
- Reset values: rom_addr = 0, stream_ready = 0, tx_word = 0, underrun_cnt = 0, done = 0, buffer empty, FSM = IDLE.
- tx_ready path:
  - Passes through a 2-flop synchronizer, then a rising-edge detector producing a 1-cycle take pulse.
  - take occurs 3 clocks after tx_ready rises.
- On take:
  - Buffer valid: tx_word <= buffer, buffer emptied.
  - Buffer empty and FSM not DONE/IDLE: tx_word <= 0, underrun_cnt += 1, saturating at all-ones.
  - In DONE or IDLE: tx_word <= 0, no count.
- tx_word holds between takes.
- FSM states: IDLE, FETCH, WAIT, LOAD, FULL, STREAM, DONE.
  - IDLE: when enable = 1, latch mode/loop/start/end and set addr = start_addr. Go to FETCH (mode 0) or STREAM (mode 1). Clear done.
  - FETCH: drive rom_addr = addr, go to WAIT.
  - WAIT: go to LOAD.
  - LOAD: buffer <= rom_data, buffer valid.
    - addr == end_addr: if loop, addr <= start_addr and go to FULL; else go to DONE.
    - Otherwise: addr <= addr + 1 and go to FULL.
  - FULL: when buffer becomes empty (take), go to FETCH the next cycle. Worst-case refill is 3 clocks after take.
  - STREAM: stream_ready = enable & buffer empty (combinational from registered state). On stream_valid & stream_ready, buffer <= stream_data, valid.
  - DONE: done = 1. The last ROM word stays in the buffer until taken. Stays in DONE until enable falls.
- Address arithmetic:
  - Wraps modulo 2^ADDR_W when end_addr < start_addr.
  - end_addr == start_addr plays a single word (repeated if loop).
- Simultaneous events:
  - take with buffer empty in the same cycle as a LOAD or stream handshake: underrun counted, tx_word <= 0, and the loaded word stays in the buffer for the next take.
  - take with buffer full in the same cycle as a stream handshake: impossible, since stream_ready requires an empty buffer.
- enable low in any state:
  - Next cycle: FSM = IDLE, buffer emptied, stream_ready = 0, done = 0.
  - tx_word and underrun_cnt hold.
  - An in-flight ROM read is discarded.
- mode/loop/addr changes outside IDLE are ignored.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

Test Plan:
- ROM non-loop: start = 2, end = 4, rom[2..4] = 8'hA1, 8'hB2, 8'hC3, enable = 1, then toggle tx_ready 4 times with a 32-clock period -> tx_word = A1, B2, C3, then 00. done = 1 after the LOAD of address 4. underrun_cnt = 0.
- ROM loop: start = 5, end = 6, rom = 8'h11, 8'h22, loop = 1, 5 takes -> tx_word sequence 11, 22, 11, 22, 11. rom_addr never exceeds 6.
- Stream underrun: mode = 1, stream_valid = 0, 3 takes -> tx_word = 00 each time, underrun_cnt = 3. Then offer 8'h5A -> stream_ready drops the cycle after acceptance; next take gives 5A.
- Saturation: CNT_W = 2, 5 underruns -> underrun_cnt = 3 and holds.
- Collision: buffer empty, stream handshake in the same cycle as the take pulse -> underrun_cnt += 1, tx_word = 00, next take outputs the handshaken word.
- Abort: enable low during WAIT, then high with start = 0 -> buffer empty, done = 0, first word after restart = rom[0]. Assert nreset mid-stream -> all outputs 0 immediately.
